lowpass_invert: RTL and testbench
=================================

# lowpass_invert

Streaming inverse of the first-order low-pass with its pole at z = 1 − 2^−L2_ALPHA. It reconstructs an estimate of the filter input from the filter's output samples using u[n] = x[n−1] + 2^L2_ALPHA·(x[n] − x[n−1]), where x is the low-pass output. The block sits downstream of a low-pass stage, in diagnostics or the feed-forward path, wherever the unsmoothed signal must be recovered. It is a two-stage pipeline with a priming state machine and a saturating output.

## Interface
- WIDTH, 30, sample width; input and output are two's-complement signed.
- L2_ALPHA, 16, log2 of the inverse pole coefficient; legal range 1..32.
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: discards history and in-flight data.
- en  in  1  input-sample strobe; may be asserted every cycle.
- x  in  WIDTH  low-pass output sample, valid when en=1.
- u  out  WIDTH  reconstructed sample, held between strobes.
- u_valid  out  1  one-cycle strobe marking a new u.
- sat  out  1  asserted with u_valid when u was clipped; held until the next u_valid.
- primed  out  1  high when a previous sample is held (state RUN).
- sat_count  out  16  saturation event counter (see Configuration).

## Operation
- States:
  - EMPTY: the reset state; also entered on clear.
  - RUN: entered after the first accepted sample.
- EMPTY + en: store x in x_prev and go to RUN. No stage-1 result is produced.
- RUN + en, stage 1 (registered):
  - d = sx(x) − sx(x_prev), WIDTH+1 bits, exact.
  - xb = x_prev, which is the old value.
  - x_prev ← x.
  - v1 ← 1.
- Stage 2, when v1=1 (registered):
  - t = (sx(d) << L2_ALPHA) + sx(xb), computed in WIDTH+L2_ALPHA+2 bits, exact with no overflow.
  - u ← t clipped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - sat ← (t was out of range).
  - u_valid ← 1.
- Clipping is symmetric saturation, never wrap-around.
- clear=1:
  - Go to EMPTY and zero v1. The next cycle's u_valid is 0.
  - u and sat keep their last values.
  - If en=1 in the same cycle, that x becomes the new primer and the state is RUN afterwards, with no output for it.
- Reset values: u=0, u_valid=0, sat=0, primed=0, sat_count=0, x_prev=0, state EMPTY.
- Reset asserted mid-stream aborts everything immediately and asynchronously. After rst_n deasserts, the first en is a primer.

## Timing
- Latency:
  - en at cycle n in RUN → u_valid high at cycle n+2.
  - u, sat and sat_count update on that same edge.
- Throughput is one sample per cycle. Back-to-back en produces back-to-back u_valid.
- A primer en never produces u_valid.
- primed rises in the cycle after the primer en is accepted. It falls in the cycle after clear or asynchronously with reset.
- en with clear: clear takes effect first, then the sample primes. The state ends in RUN.
- Gaps in en are permitted: x_prev holds indefinitely and u holds its value.

## Configuration
- LOWPASS_INVERT_SATCOUNT_EN:
  - Defined: sat_count is a 16-bit counter incremented on every u_valid with sat=1. It saturates at 0xFFFF and is cleared by reset only, not by clear.
  - Undefined: no counter logic is built and sat_count is driven constant 0.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=16 and L2_ALPHA=4.
- Constant input: reset, then en with x=1000 for 8 cycles. Required: first sample primes; u_valid on 7 samples, each 2 cycles after its en, each u=1000; sat=0.
- Step: en sequence x = 0, 100, 100, 100. Required: u = 1600, 100, 100; sat=0; primed=1 from cycle 2.
- Positive saturation: x = 0 then 30000. Required: u=32767, sat=1, sat_count=1 (0 if the macro is undefined).
- Negative saturation: x = 0 then −30000. Required: u=−32768, sat=1, sat_count=2 if the macro is defined. Continuous en for 70000 clipped samples: sat_count sticks at 0xFFFF.
- clear in the cycle after a RUN en: no u_valid for that sample; primed drops. clear together with en x=500: primed=1 next cycle. Then en x=500: u=500.
- Round trip: a step of 4096 through a 16-bit lowpass (L2_ALPHA=4) feeds this block. Required: the reconstructed u is within ±16 of 4096 after the step.
- Reset mid-stream: assert rst_n=0 between an en and its u_valid. Required: no u_valid; all outputs 0; the first en after release primes.

Source files
------------

// File: rtl/lowpass_invert_if.sv
// -----------------------------------------------------------------------------
// lowpass_invert_if
// Sample-stream bundle for lowpass_invert.
//   clear     : synchronous restart request (master -> slave)
//   en        : input-sample strobe         (master -> slave)
//   x         : low-pass output sample      (master -> slave)
//   u         : reconstructed sample        (slave -> master)
//   u_valid   : one-cycle strobe for new u  (slave -> master)
//   sat       : u was clipped               (slave -> master)
//   primed    : previous sample is held     (slave -> master)
//   sat_count : saturation event counter    (slave -> master)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface lowpass_invert_if #(
   parameter int WIDTH = 30
);
   logic                    clear;
   logic                    en;
   logic signed [WIDTH-1:0] x;
   logic signed [WIDTH-1:0] u;
   logic                    u_valid;
   logic                    sat;
   logic                    primed;
   logic [15:0]             sat_count;

   modport master (
      output clear, en, x,
      input  u, u_valid, sat, primed, sat_count
   );

   modport slave (
      input  clear, en, x,
      output u, u_valid, sat, primed, sat_count
   );
endinterface

// File: rtl/lowpass_invert.sv
// -----------------------------------------------------------------------------
// lowpass_invert
// Streaming inverse of a first-order low-pass with pole 1 - 2^-L2_ALPHA:
//   u[n] = x[n-1] + 2^L2_ALPHA * (x[n] - x[n-1]), clipped to WIDTH bits.
// Two-stage pipeline (difference, then scale/add/saturate) behind a
// two-state priming FSM (EMPTY -> RUN).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lowpass_invert_if.slave (clear, en, x in; u, u_valid, sat,
//           primed, sat_count out)
//
// Build option:
//   LOWPASS_INVERT_SATCOUNT_EN : when defined, sat_count is a saturating
//   16-bit count of clipped outputs (cleared by reset only); otherwise it
//   is tied to zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lowpass_invert #(
   parameter int WIDTH    = 30,
   parameter int L2_ALPHA = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   lowpass_invert_if.slave bus
);

   // Wide enough for the shifted (WIDTH+1)-bit difference plus x_prev.
   localparam int TW = WIDTH + L2_ALPHA + 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_run_accept;

   logic signed [WIDTH-1:0] r_x_prev;
   logic signed [WIDTH:0]   r_d_p1;
   logic signed [WIDTH-1:0] r_xb_p1;
   logic                    r_vld_p1;

   logic signed [TW-1:0]    w_d_ext;
   logic signed [TW-1:0]    w_xb_ext;
   logic signed [TW-1:0]    w_t;
   logic                    w_fire_p2;

   logic signed [WIDTH-1:0] r_u_p2;
   logic                    r_sat_p2;
   logic                    r_vld_p2;

   // In range iff every bit from the sign of the WIDTH-bit result upward
   // agrees; anything else cannot be represented in WIDTH bits.
   function automatic logic is_ovf(input logic signed [TW-1:0] t);
      logic [TW-WIDTH:0] top;
      top = t[TW-1:WIDTH-1];
      return !((&top) || !(|top));
   endfunction

   function automatic logic signed [WIDTH-1:0] clip(input logic signed [TW-1:0] t);
      logic signed [WIDTH-1:0] res;
      if (is_ovf(t)) begin
         res = t[TW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res = t[WIDTH-1:0];
      end
      return res;
   endfunction

   // Clear is applied before the sample: en with clear re-primes.
   always_comb begin
      w_state_nxt  = r_state;
      w_run_accept = 1'b0;
      if (bus.clear) begin
         w_state_nxt = ST_EMPTY;
      end
      if (bus.en) begin
         w_state_nxt  = ST_RUN;
         w_run_accept = (r_state == ST_RUN) && !bus.clear;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---- stage 1: exact difference against the held previous sample ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x_prev <= '0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= w_run_accept;
         if (bus.en) begin
            r_x_prev <= bus.x;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_run_accept) begin
         r_d_p1  <= $signed({bus.x[WIDTH-1], bus.x}) - $signed({r_x_prev[WIDTH-1], r_x_prev});
         r_xb_p1 <= r_x_prev;
      end
   end

   // ---- stage 2: scale, add, saturate ----
   assign w_d_ext   = {{(TW-WIDTH-1){r_d_p1[WIDTH]}}, r_d_p1};
   assign w_xb_ext  = {{(TW-WIDTH){r_xb_p1[WIDTH-1]}}, r_xb_p1};
   assign w_t       = (w_d_ext <<< L2_ALPHA) + w_xb_ext;
   // clear also kills a result already sitting in stage 1.
   assign w_fire_p2 = r_vld_p1 && !bus.clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_u_p2   <= '0;
         r_sat_p2 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p2 <= w_fire_p2;
         if (w_fire_p2) begin
            r_u_p2   <= clip(w_t);
            r_sat_p2 <= is_ovf(w_t);
         end
      end
   end

`ifdef LOWPASS_INVERT_SATCOUNT_EN
   logic [15:0] r_sat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_cnt <= '0;
      end else if (w_fire_p2 && is_ovf(w_t) && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign bus.sat_count = r_sat_cnt;
`else
   assign bus.sat_count = 16'd0;
`endif

   assign bus.u       = r_u_p2;
   assign bus.u_valid = r_vld_p2;
   assign bus.sat     = r_sat_p2;
   assign bus.primed  = (r_state == ST_RUN);

endmodule

// File: tb/tb_lowpass_invert.sv
`timescale 1ns/1ps
module tb_lowpass_invert;

   localparam int W  = 16;
   localparam int LA = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   lowpass_invert_if #(.WIDTH(W)) bus ();

   lowpass_invert #(.WIDTH(W), .L2_ALPHA(LA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then return 1 time unit after the edge.
   task automatic cyc(input logic e, input logic signed [W-1:0] xv, input logic c);
      bus.en    = e;
      bus.x     = xv;
      bus.clear = c;
      @(posedge clk);
      #1;
      bus.en    = 1'b0;
      bus.clear = 1'b0;
   endtask

   logic [15:0] exp_cnt1, exp_cnt2;
   int y, diff;

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.en    = 1'b0;
      bus.clear = 1'b0;
      bus.x     = '0;
`ifdef LOWPASS_INVERT_SATCOUNT_EN
      exp_cnt1 = 16'd1;
      exp_cnt2 = 16'd2;
`else
      exp_cnt1 = 16'd0;
      exp_cnt2 = 16'd0;
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_u",       bus.u, 0);
      chk("rst_u_valid", bus.u_valid, 0);
      chk("rst_sat",     bus.sat, 0);
      chk("rst_primed",  bus.primed, 0);
      chk("rst_satcnt",  bus.sat_count, 0);
      rst_n = 1'b1;

      // Constant input 1000: primer, then 7 outputs of 1000
      cyc(1'b1, 16'sd1000, 1'b0);
      chk("const_prime_uv",     bus.u_valid, 0);
      chk("const_prime_primed", bus.primed, 1);
      for (int k = 1; k <= 9; k++) begin
         cyc(k <= 7, 16'sd1000, 1'b0);
         chk("const_uv", bus.u_valid, (k >= 2 && k <= 8) ? 1 : 0);
         if (k >= 2 && k <= 8) begin
            chk("const_u",   bus.u, 1000);
            chk("const_sat", bus.sat, 0);
         end
      end

      // Step 0,100,100,100
      cyc(1'b0, 16'sd0, 1'b1);
      chk("clr_primed", bus.primed, 0);
      cyc(1'b1, 16'sd0, 1'b0);
      chk("step_primed", bus.primed, 1);
      chk("step_uv0", bus.u_valid, 0);
      cyc(1'b1, 16'sd100, 1'b0);
      chk("step_uv1", bus.u_valid, 0);
      cyc(1'b1, 16'sd100, 1'b0);
      chk("step_uv2", bus.u_valid, 1);
      chk("step_u2",  bus.u, 1600);
      chk("step_sat2", bus.sat, 0);
      cyc(1'b1, 16'sd100, 1'b0);
      chk("step_uv3", bus.u_valid, 1);
      chk("step_u3",  bus.u, 100);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("step_uv4", bus.u_valid, 1);
      chk("step_u4",  bus.u, 100);
      chk("step_primed4", bus.primed, 1);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("step_uv5", bus.u_valid, 0);
      chk("step_hold_u", bus.u, 100);

      // Positive saturation (clear+en primes with 0)
      cyc(1'b1, 16'sd0, 1'b1);
      chk("psat_primed", bus.primed, 1);
      cyc(1'b1, 16'sd30000, 1'b0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("psat_uv",  bus.u_valid, 1);
      chk("psat_u",   bus.u, 32767);
      chk("psat_sat", bus.sat, 1);
      chk("psat_cnt", bus.sat_count, exp_cnt1);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("psat_uv_off",   bus.u_valid, 0);
      chk("psat_sat_hold", bus.sat, 1);

      // Negative saturation
      cyc(1'b1, 16'sd0, 1'b1);
      cyc(1'b1, -16'sd30000, 1'b0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("nsat_uv",  bus.u_valid, 1);
      chk("nsat_u",   bus.u, -32768);
      chk("nsat_sat", bus.sat, 1);
      chk("nsat_cnt", bus.sat_count, exp_cnt2);

`ifdef LOWPASS_INVERT_SATCOUNT_EN
      // 70000 clipped samples: counter sticks at 0xFFFF
      for (int i = 0; i < 70000; i++) begin
         cyc(1'b1, (i % 2 == 0) ? 16'sd30000 : -16'sd30000, 1'b0);
      end
      cyc(1'b0, 16'sd0, 1'b0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("cnt_stick", bus.sat_count, 32'h0000FFFF);
`endif

      // clear in the cycle after a RUN en
      cyc(1'b1, 16'sd0, 1'b1);
      cyc(1'b1, 16'sd100, 1'b0);
      cyc(1'b0, 16'sd0, 1'b1);
      chk("clr_kill_primed", bus.primed, 0);
      chk("clr_kill_uv0", bus.u_valid, 0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("clr_kill_uv1", bus.u_valid, 0);
      cyc(1'b1, 16'sd500, 1'b1);
      chk("clr_en_primed", bus.primed, 1);
      chk("clr_en_uv", bus.u_valid, 0);
      cyc(1'b1, 16'sd500, 1'b0);
      chk("clr_en_uv1", bus.u_valid, 0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("clr_en_uv2", bus.u_valid, 1);
      chk("clr_en_u",   bus.u, 500);
      chk("clr_en_sat", bus.sat, 0);

      // Round trip through a 16-bit lowpass, step to 4096
      y = 0;
      cyc(1'b1, 16'sd0, 1'b1);
      for (int n = 0; n < 10; n++) begin
         y = y + ((4096 - y) >>> LA);
         cyc(1'b1, W'(y), 1'b0);
         cyc(1'b0, 16'sd0, 1'b0);
         chk("rt_uv", bus.u_valid, 1);
         diff = int'(bus.u) - 4096;
         chk("rt_within16", (diff >= -16 && diff <= 16) ? 1 : 0, 1);
      end

      // Reset mid-stream between en and its u_valid
      cyc(1'b1, 16'sd10, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_u",      bus.u, 0);
      chk("mrst_uv",     bus.u_valid, 0);
      chk("mrst_sat",    bus.sat, 0);
      chk("mrst_primed", bus.primed, 0);
      chk("mrst_cnt",    bus.sat_count, 0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("mrst_uv_a", bus.u_valid, 0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("mrst_uv_b", bus.u_valid, 0);
      #2 rst_n = 1'b1;
      cyc(1'b1, 16'sd77, 1'b0);
      chk("post_primed", bus.primed, 1);
      chk("post_uv0", bus.u_valid, 0);
      cyc(1'b1, 16'sd77, 1'b0);
      chk("post_uv1", bus.u_valid, 0);
      cyc(1'b0, 16'sd0, 1'b0);
      chk("post_uv2", bus.u_valid, 1);
      chk("post_u",   bus.u, 77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
